aes_req_sched: RTL

//  Round-robin scheduler sharing one iterative aes_core among NREQ requesters.

---
 rtl/aes_req_sched_pkg.sv | 18 +
 rtl/aes_req_sched_rr_arbiter.sv | 42 ++++
 rtl/aes_req_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aes_req_sched_pkg.sv
// Shared types and constants for the round-robin AES request scheduler.
// Bit 127 of every 128-bit block is the first (most significant) bit the core sees.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } sched_state_e;

  localparam int AES_LAT = 11;

  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one iterative aes_core among NREQ requesters: round-robin accept, load, wait for done
// (with timeout), then hold the result on a single valid/ready response port.
module aes_req_sched
  import aes_sched_pkg::*;
#(
  parameter  int NREQ     = 2,
  parameter  int TAG_W    = 4,
  parameter  int WAIT_MAX = 16,
  localparam int SRC_W    = src_width(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*128-1:0]     req_key,
  input  logic [NREQ*128-1:0]     req_text,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [127:0]            rsp_data,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [SRC_W-1:0]        rsp_src,
  output logic                    aes_ld,
  output logic [127:0]            aes_key,
  output logic [127:0]            aes_text_in,
  input  logic                    aes_done,
  input  logic [127:0]            aes_text_out,
  output logic                    busy,
  output logic                    err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  sched_state_e       state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       text_q, text_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [127:0]       data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               valid_q, ld_q, busy_q;

  logic [NREQ-1:0]    gnt_s;
  logic [SRC_W-1:0]   gnt_idx_s;
  logic               gnt_any_s;
  logic [127:0]       key_sel_s;
  logic [127:0]       text_sel_s;
  logic [TAG_W-1:0]   tag_sel_s;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (SRC_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (gnt_any_s)
  );

  // One-hot AND-OR mux of the granted requester's payload.
  always_comb begin
    key_sel_s  = '0;
    text_sel_s = '0;
    tag_sel_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      key_sel_s  = key_sel_s  | (req_key[i*128 +: 128]     & {128{gnt_s[i]}});
      text_sel_s = text_sel_s | (req_text[i*128 +: 128]    & {128{gnt_s[i]}});
      tag_sel_s  = tag_sel_s  | (req_tag[i*TAG_W +: TAG_W] & {TAG_W{gnt_s[i]}});
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    key_d     = key_q;
    text_d    = text_q;
    tag_d     = tag_q;
    src_d     = src_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt_s;
        if (gnt_any_s) begin
          key_d   = key_sel_s;
          text_d  = text_sel_s;
          tag_d   = tag_sel_s;
          src_d   = gnt_idx_s;
          ptr_d   = (gnt_idx_s == SRC_W'(NREQ - 1)) ? '0 : gnt_idx_s + SRC_W'(1);
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Core still reports done while idle, so done is only meaningful from RUN on.
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (aes_done) begin
          data_d  = aes_text_out;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      tag_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      text_q  <= text_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= (state_d == ST_RESP);
      ld_q    <= (state_d == ST_LOAD);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign rsp_valid   = valid_q;
  assign rsp_data    = data_q;
  assign rsp_tag     = tag_q;
  assign rsp_src     = src_q;
  assign aes_ld      = ld_q;
  assign aes_key     = key_q;
  assign aes_text_in = text_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
